// File: rtl/comm_tx_arb.sv
// Four-port half-duplex transmit arbiter: lends one shared serial stream to one
// line driver at a time, framing it with lead, lag and bus-quiet guard times.
module comm_tx_arb #(
  parameter int LEAD    = 16,
  parameter int LAG     = 16,
  parameter int GAP     = 8,
  parameter int MAXHOLD = 0,
  parameter int CW      = 16
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic [3:0] req_i,
  input  logic [3:0] en_i,
  input  logic       tx_i,
  output logic [3:0] gnt_o,
  output logic [3:0] txd_o,
  output logic [3:0] txen_o,
  output logic [1:0] ch_o,
  output logic       busy_o,
  output logic       timeout_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD,
    S_DATA,
    S_LAG,
    S_GAP
  } state_t;

  localparam logic [CW-1:0] LEAD_M1 = CW'(LEAD - 1);
  localparam logic [CW-1:0] LAG_M1  = CW'(LAG - 1);
  localparam logic [CW-1:0] GAP_M1  = CW'(GAP - 1);
  localparam logic [CW-1:0] HOLD_M1 = CW'(MAXHOLD - 1);
  localparam bit            HOLD_EN = (MAXHOLD != 0);

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [1:0]    last_reg, last_next;
  logic [1:0]    ch_reg, ch_next;
  logic          timeout_next;
  logic [3:0]    gnt_reg, txen_reg;
  logic          busy_reg, timeout_reg;

  logic [3:0] elig;
  logic [1:0] cand [4];
  logic [3:0] hit;
  logic [1:0] pick;
  logic       pick_valid;

  assign elig = req_i & en_i;

  // cand[0] is the port right after the last winner; the last winner itself is scanned last
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_scan
      assign cand[gi] = last_reg + 2'(gi + 1);
      assign hit[gi]  = elig[cand[gi]];
    end
  endgenerate

  always_comb begin
    pick       = cand[3];
    pick_valid = |hit;
    for (int i = 3; i >= 0; i--) begin
      if (hit[i]) pick = cand[i];
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    last_next    = last_reg;
    ch_next      = ch_reg;
    timeout_next = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (pick_valid) begin
          ch_next    = pick;
          last_next  = pick;
          cnt_next   = LEAD_M1;
          state_next = S_LEAD;
        end
      end
      S_LEAD: begin
        if (cnt_reg == '0) begin
          state_next = S_DATA;
          cnt_next   = HOLD_M1;
        end else begin
          cnt_next = cnt_reg - CW'(1);
        end
      end
      S_DATA: begin
        // the hold limit reports a timeout even if the request drops on the same edge
        if (HOLD_EN && cnt_reg == '0) begin
          state_next   = S_LAG;
          cnt_next     = LAG_M1;
          timeout_next = 1'b1;
        end else if (!(req_i[ch_reg] && en_i[ch_reg])) begin
          state_next = S_LAG;
          cnt_next   = LAG_M1;
        end else begin
          cnt_next = cnt_reg - CW'(1);
        end
      end
      S_LAG: begin
        if (cnt_reg == '0) begin
          state_next = S_GAP;
          cnt_next   = GAP_M1;
        end else begin
          cnt_next = cnt_reg - CW'(1);
        end
      end
      S_GAP: begin
        if (cnt_reg == '0) begin
          state_next = S_IDLE;
        end else begin
          cnt_next = cnt_reg - CW'(1);
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // status outputs are computed from the next state so they are true flops
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_reg   <= S_IDLE;
      cnt_reg     <= '0;
      last_reg    <= 2'd3;
      ch_reg      <= 2'd0;
      gnt_reg     <= '0;
      txen_reg    <= '0;
      busy_reg    <= 1'b0;
      timeout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      last_reg    <= last_next;
      ch_reg      <= ch_next;
      gnt_reg     <= (state_next == S_DATA) ? (4'b0001 << ch_next) : 4'b0000;
      txen_reg    <= (state_next == S_LEAD || state_next == S_DATA || state_next == S_LAG)
                     ? (4'b0001 << ch_next) : 4'b0000;
      busy_reg    <= (state_next != S_IDLE);
      timeout_reg <= timeout_next;
    end
  end

  assign gnt_o     = gnt_reg;
  assign txen_o    = txen_reg;
  assign busy_o    = busy_reg;
  assign timeout_o = timeout_reg;
  assign ch_o      = ch_reg;

  generate
    for (gi = 0; gi < 4; gi++) begin : g_txd
      assign txd_o[gi] = (state_reg == S_DATA && ch_reg == 2'(gi)) ? tx_i : 1'b1;
    end
  endgenerate

endmodule

// File: tb/tb_comm_tx_arb.sv
// Bench for comm_tx_arb: a timestamp-based arbitration model predicts whole
// transactions; a monitor rebuilds them from the pins and scores them.
module tb_comm_tx_arb;
  localparam int LEAD    = 4;
  localparam int LAG     = 3;
  localparam int GAP     = 2;
  localparam int MAXHOLD = 20;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [3:0] req = 4'b0000;
  logic [3:0] en = 4'b1111;
  logic       tx = 1'b1;
  logic [3:0] gnt_o, txd_o, txen_o;
  logic [1:0] ch_o;
  logic       busy_o, timeout_o;

  comm_tx_arb #(.LEAD(LEAD), .LAG(LAG), .GAP(GAP), .MAXHOLD(MAXHOLD), .CW(16)) dut (
    .clk_i(clk), .rstn_i(rstn), .req_i(req), .en_i(en), .tx_i(tx),
    .gnt_o(gnt_o), .txd_o(txd_o), .txen_o(txen_o), .ch_o(ch_o),
    .busy_o(busy_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int port;
    int start;
    int dlen;
    int tmo;
  } txn_t;

  txn_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   txen2_cycles = 0;

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Reference model: arbitration decisions plus edge timestamps of each phase
  int m_mode = 0;  // 0 free, 1 lead/data, 2 lag+gap tail
  int m_last = 3;
  int m_port, m_start, m_grant_edge, m_free_edge;
  bit exp_busy = 1'b0;

  initial forever begin
    @(posedge clk or negedge rstn);
    if (!rstn) begin
      m_mode = 0;
      m_last = 3;
      exp_busy = 1'b0;
      exp_q.delete();
    end else begin
      cyc++;
      if (m_mode == 0) begin
        for (int k = 1; k <= 4; k++) begin
          int p;
          p = (m_last + k) % 4;
          if (m_mode == 0 && req[p] && en[p]) begin
            m_port = p;
            m_last = p;
            m_start = cyc;
            m_grant_edge = cyc + LEAD;
            m_mode = 1;
          end
        end
      end else if (m_mode == 1) begin
        if (cyc > m_grant_edge) begin
          int  el;
          bit  tmo;
          el  = cyc - m_grant_edge;
          tmo = (MAXHOLD != 0) && (el == MAXHOLD);
          if (tmo || !req[m_port] || !en[m_port]) begin
            exp_q.push_back('{port: m_port, start: m_start, dlen: el, tmo: int'(tmo)});
            m_free_edge = cyc + LAG + GAP;
            m_mode = 2;
          end
        end
      end else if (cyc == m_free_edge) begin
        m_mode = 0;
      end
      exp_busy = (m_mode != 0);
    end
  end

  // Monitor: reconstruct each txen pulse from the pins, then score it
  bit in_pulse = 1'b0;
  bit have_fall = 1'b0;
  int mp, rise, lead_n, dlen_n, lag_n, tcnt, fall;

  initial forever begin
    @(negedge clk);
    if (!rstn) begin
      in_pulse = 1'b0;
      have_fall = 1'b0;
    end else begin
      if (txen_o[2]) txen2_cycles++;
      chk("busy", int'(busy_o), int'(exp_busy));
      if (!in_pulse && txen_o != 4'b0000) begin
        in_pulse = 1'b1;
        mp = txen_o[0] ? 0 : txen_o[1] ? 1 : txen_o[2] ? 2 : 3;
        rise = cyc;
        lead_n = 0; dlen_n = 0; lag_n = 0; tcnt = 0;
        if (have_fall) chk("quiet_gap_min", int'((cyc - fall) >= GAP + 1), 1);
      end
      if (in_pulse && txen_o == 4'b0000) begin
        in_pulse = 1'b0;
        fall = cyc;
        have_fall = 1'b1;
        if (exp_q.size() == 0) begin
          fail_now($sformatf("unexpected_txn port=%0d rise=%0d", mp, rise));
        end else begin
          txn_t e;
          e = exp_q.pop_front();
          chk("txn_port", mp, e.port);
          chk("txn_rise", rise, e.start);
          chk("txn_lead", lead_n, LEAD);
          chk("txn_data_len", dlen_n, e.dlen);
          chk("txn_lag", lag_n, LAG);
          chk("txn_timeout", tcnt, e.tmo);
          $display("txn port=%0d rise=%0d lead=%0d data=%0d lag=%0d timeout=%0d",
                   mp, rise, lead_n, dlen_n, lag_n, tcnt);
        end
      end
      if (in_pulse) begin
        chk("txen_onehot", int'(txen_o), 1 << mp);
        chk("ch", int'(ch_o), mp);
        if (gnt_o[mp]) begin
          dlen_n++;
          chk("gnt_onehot", int'(gnt_o), 1 << mp);
          chk("txd_data", int'(txd_o[mp]), int'(tx));
          chk("gnt_after_lag", lag_n, 0);
        end else begin
          chk("gnt_guard", int'(gnt_o), 0);
          chk("txd_guard", int'(txd_o[mp]), 1);
          if (dlen_n == 0) lead_n++;
          else lag_n++;
        end
        if (timeout_o) begin
          tcnt++;
          chk("timeout_pos", lag_n, 1);
        end
      end else begin
        chk("gnt_idle", int'(gnt_o), 0);
        chk("timeout_idle", int'(timeout_o), 0);
      end
      for (int p = 0; p < 4; p++) begin
        if (!in_pulse || p != mp) chk("idle_port_lines", int'({txen_o[p], txd_o[p]}), 1);
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1 tx = 1'($urandom_range(0, 1));
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (!busy_o && !exp_busy) begin
        ok = 1'b1;
        break;
      end
      step(1);
    end
    if (!ok) fail_now("wait_idle_expired");
    step(1);
  endtask

  task automatic wait_gnt(input int port);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step(1);
      if (gnt_o[port]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_now($sformatf("wait_gnt_expired port=%0d", port));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int t2;
    #3;
    chk("rst_gnt", int'(gnt_o), 0);
    chk("rst_txen", int'(txen_o), 0);
    chk("rst_txd", int'(txd_o), 15);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_timeout", int'(timeout_o), 0);
    chk("rst_ch", int'(ch_o), 0);
    step(2);
    rstn = 1'b1;
    step(2);

    // single port, 10 data cycles
    req = 4'b0001;
    wait_gnt(0);
    step(9);
    req = 4'b0000;
    wait_idle();

    // all ports requesting continuously
    req = 4'b1111;
    step(160);
    req = 4'b0000;
    wait_idle();

    // port 2 masked off
    t2 = txen2_cycles;
    req = 4'b0110;
    en = 4'b1011;
    step(60);
    chk("txen2_never", txen2_cycles - t2, 0);
    req = 4'b0000;
    en = 4'b1111;
    wait_idle();

    // hold limit with port 0 stuck
    req = 4'b1001;
    step(80);
    req = 4'b0000;
    wait_idle();

    // asynchronous reset in DATA on port 2
    req = 4'b0100;
    wait_gnt(2);
    step(3);
    #2 rstn = 1'b0;
    #1;
    chk("arst_gnt", int'(gnt_o), 0);
    chk("arst_txen", int'(txen_o), 0);
    chk("arst_txd", int'(txd_o), 15);
    chk("arst_busy", int'(busy_o), 0);
    chk("arst_timeout", int'(timeout_o), 0);
    req = 4'b1111;
    step(2);
    rstn = 1'b1;
    wait_gnt(0);
    chk("first_after_reset", int'(gnt_o), 1);
    step(40);
    req = 4'b0000;
    wait_idle();

    // single-cycle request pulse
    req = 4'b0010;
    step(1);
    req = 4'b0000;
    wait_idle();

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0) req = req ^ (4'b0001 << $urandom_range(0, 3));
      if ($urandom_range(0, 63) == 0) en = 4'($urandom_range(0, 15));
      step(1);
    end
    req = 4'b0000;
    en = 4'b1111;
    wait_idle();
    step(2);
    chk("leftover_expected", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/comm_tx_arb.md
# comm_tx_arb

Four-port half-duplex transmit arbiter for the A–D line drivers. One shared serial transmit stream (`tx_i`) is lent to one port at a time. The block sequences that port's driver enable with lead, lag and turnaround guard times, and routes the data only during the granted window. It sits between the MCU UART and the `*_TXD`/`*_TXEN` pins; the per-port enable mask comes from the SPI control register.

## Interface
Parameters:
- `LEAD`, 16: cycles TXEN is asserted, with the line idle-high, before data passes; must be ≥1.
- `LAG`, 16: cycles TXEN is held, line idle-high, after the grant ends; must be ≥1.
- `GAP`, 8: bus-quiet cycles after TXEN drops, before any new grant; must be ≥1.
- `MAXHOLD`, 0: maximum DATA-state length in cycles; 0 disables the limit.
- `CW`, 16: width of the guard/hold counter. All of `LEAD`, `LAG`, `GAP` and `MAXHOLD` must be < 2^CW.

Ports:
- `clk_i`  in  1  system clock
- `rstn_i`  in  1  reset; one clock, asynchronous assert, active-low
- `req_i`  in  4  level transmit request per port; held high for the whole message
- `en_i`  in  4  port enable mask; a port with `en_i=0` is never granted
- `tx_i`  in  1  shared serial data
- `gnt_o`  out  4  one-hot grant; high only in DATA
- `txd_o`  out  4  per-port line data
- `txen_o`  out  4  per-port driver enable
- `ch_o`  out  2  selected port index
- `busy_o`  out  1  high in any state other than IDLE
- `timeout_o`  out  1  one-cycle pulse when the `MAXHOLD` limit fires

## Operation
- States are IDLE, LEAD, DATA, LAG and GAP. There is a single down-counter `cnt[CW-1:0]` and a round-robin pointer `last[1:0]`.
- IDLE:
  - Eligible set `e = req_i & en_i`.
  - If `e≠0`, pick the first set bit scanning `last+1`, `last+2`, … (mod 4). Then `ch←pick`, `last←pick`, `cnt←LEAD-1`, go to LEAD.
- LEAD:
  - `txen_o[ch]=1`, `txd_o[ch]=1`.
  - When `cnt==0`: go to DATA, `cnt←MAXHOLD-1`. Otherwise `cnt--`.
  - Dropping the request during LEAD does not abort LEAD; the DATA exit condition is evaluated on the first DATA cycle.
- DATA:
  - `gnt_o[ch]=1`, `txen_o[ch]=1`, `txd_o[ch]=tx_i` (combinational mux).
  - Exit to LAG with `cnt←LAG-1` when `req_i[ch]==0` or `en_i[ch]==0`.
  - If `MAXHOLD≠0` and `cnt==0`, also exit to LAG and pulse `timeout_o`. Otherwise `cnt--`.
- LAG: `txen_o[ch]=1`, `txd_o[ch]=1`. When `cnt==0`, go to GAP with `cnt←GAP-1`.
- GAP: all `txen_o=0`. When `cnt==0`, go to IDLE.
- Unselected ports always have `txd_o=1` and `txen_o=0`.
- Simultaneous requests: round-robin order only; no port is granted twice while another eligible port waits.
- A timed-out port is not blocked. It simply takes lowest priority on the next arbitration.
- Changing `en_i` for a non-selected port has no effect until the next IDLE.
- Reset (asynchronous, any state):
  - state IDLE, `last=3` (port 0 wins first), `ch=0`, `cnt=0`.
  - `gnt_o=0`, `txen_o=0`, `txd_o=4'b1111`, `busy_o=0`, `timeout_o=0`.

## Timing
- `gnt_o`, `txen_o`, `ch_o`, `busy_o` and `timeout_o` are registered. `txd_o` in DATA has zero latency from `tx_i`.
- Request sampled high in IDLE at edge k:
  - `txen_o` and `busy_o` rise after edge k.
  - `gnt_o` rises after edge k+LEAD.
- Request sampled low in DATA at edge m:
  - `gnt_o` falls after m.
  - `txen_o` falls after m+LAG.
  - State returns to IDLE after m+LAG+GAP.
  - The next `txen_o` rises no earlier than after m+LAG+GAP+1, i.e. a minimum quiet time of GAP+1 cycles.
- With `MAXHOLD=N`, DATA lasts exactly N cycles. `timeout_o` is high in the cycle after the Nth.

## Test plan
- LEAD=4, LAG=3, GAP=2; `req_i=0001`, `en_i=1111`, held 10 cycles after grant, then dropped.
  - `txen_o[0]` high 4 cycles before `gnt_o[0]`.
  - `gnt_o` high 10 cycles, `txen_o[0]` 3 more cycles.
  - `busy_o` low 2 cycles after that.
  - `txd_o[0]` follows `tx_i` only while granted; the other ports stay at 1/0.
- `req_i=1111` held continuously: grants come in order 0,1,2,3,0. Consecutive `txen_o` pulses are separated by exactly GAP+1=3 low cycles.
- `req_i=0110`, `en_i=1011`: only port 1 is ever granted; `txen_o[2]` never rises.
- MAXHOLD=20, `req_i[0]` stuck high, `req_i[3]` high: port 0 gets 20 DATA cycles, then `timeout_o` pulses once, then port 3 is granted next.
- Assert `rstn_i=0` mid-DATA on port 2: `txen_o`, `gnt_o` and `busy_o` go to 0 and `txd_o` to 1111 without waiting for a clock edge. After release with `req_i=1111`, port 0 is granted first.
- `req_i[1]` pulsed high for a single cycle in IDLE: a full LEAD is run, then a one-cycle DATA with `gnt_o[1]` high for 1 cycle, then LAG and GAP.
